// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer bus of the parametrised UART receiver.
//   dout        received word, LSB = first data bit on the line
//   valid       dout holds an unconsumed word
//   ready       consumer accepts dout when valid && ready
//   parity_err  one-cycle pulse: parity mismatch
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: good frame dropped while valid was still high
//   busy        receiver is not idle
// master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] dout;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output dout, valid, parity_err, frame_err, overrun, busy,
    input  ready
  );

  modport slave (
    input  dout, valid, parity_err, frame_err, overrun, busy,
    output ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 16x oversampling and 3-sample majority vote.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high
//   rxd  asynchronous serial line, idles high
//   bus  receiver side of uart_rx_param_if (word, valid/ready, error pulses, busy)
module uart_rx_param #(
  parameter int unsigned CLK_FREQ    = 40000000,
  parameter int unsigned BAUD        = 38400,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxd,
  uart_rx_param_if.master bus
);

  localparam int unsigned DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone} state_e;

  state_e               state_q, state_d;
  logic [DivW-1:0]      div_q;
  logic                 tick;
  logic                 sync1_q, rxs_q;
  logic [3:0]           scnt_q;
  logic                 samp7_q, samp8_q;
  logic                 maj;
  logic                 mid, last;
  logic [BitW-1:0]      bitcnt_q;
  logic                 last_bit;
  logic                 stopcnt_q;
  logic                 last_stop;
  logic [DATA_BITS-1:0] shift_q, dout_q;
  logic                 exp_par;
  logic                 par_bad_q, frame_bad_q;
  logic                 valid_q, parity_err_q, frame_err_q, overrun_q;
  logic                 start_entry;
  logic                 done, load, ovr;

  assign tick      = (div_q == DivW'(DIV - 1));
  // Samples at scnt 7 and 8 are held; the third is rxs itself at scnt 9.
  assign maj       = (samp7_q & samp8_q) | (samp7_q & rxs_q) | (samp8_q & rxs_q);
  assign mid       = tick && (scnt_q == 4'd9);
  assign last      = tick && (scnt_q == 4'd15);
  assign last_bit  = (bitcnt_q == BitW'(DATA_BITS - 1));
  assign last_stop = (STOP_BITS == 1) || stopcnt_q;
  assign exp_par   = (PARITY_MODE == 2) ? ~^shift_q : ^shift_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_entry = 1'b0;
    done        = 1'b0;
    load        = 1'b0;
    ovr         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick && !rxs_q) begin
          state_d     = StStart;
          start_entry = 1'b1;
        end
      end
      StStart: begin
        if (mid && maj)  state_d = StIdle;  // false start
        else if (last)   state_d = StData;
      end
      StData: begin
        if (last && last_bit) state_d = (PARITY_MODE != 0) ? StParity : StStop;
      end
      StParity: begin
        if (last) state_d = StStop;
      end
      StStop: begin
        // Leave at mid-bit so a following start edge is not missed.
        if (mid && last_stop) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        done    = 1'b1;
        if (!frame_bad_q && !par_bad_q) begin
          ovr  = valid_q && !bus.ready;
          load = !ovr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      scnt_q       <= '0;
      samp7_q      <= 1'b1;
      samp8_q      <= 1'b1;
      bitcnt_q     <= '0;
      stopcnt_q    <= 1'b0;
      shift_q      <= '0;
      dout_q       <= '0;
      par_bad_q    <= 1'b0;
      frame_bad_q  <= 1'b0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      div_q   <= tick ? '0 : div_q + DivW'(1);
      sync1_q <= rxd;
      rxs_q   <= sync1_q;

      if (tick) scnt_q <= scnt_q + 4'd1;
      if (tick && (scnt_q == 4'd7)) samp7_q <= rxs_q;
      if (tick && (scnt_q == 4'd8)) samp8_q <= rxs_q;

      if (start_entry) begin
        scnt_q      <= '0;
        bitcnt_q    <= '0;
        stopcnt_q   <= 1'b0;
        par_bad_q   <= 1'b0;
        frame_bad_q <= 1'b0;
      end

      if (state_q == StData) begin
        if (mid)  shift_q[bitcnt_q] <= maj;
        if (last) bitcnt_q <= last_bit ? '0 : bitcnt_q + BitW'(1);
      end

      if ((state_q == StParity) && mid) par_bad_q <= (maj != exp_par);

      if ((state_q == StStop) && mid) begin
        if (!maj) frame_bad_q <= 1'b1;
        stopcnt_q <= 1'b1;
      end

      parity_err_q <= done && !frame_bad_q && par_bad_q;
      frame_err_q  <= done && frame_bad_q;
      overrun_q    <= ovr;

      // A load in the same clk as a handshake keeps valid high with the new word.
      if (load) begin
        dout_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: two instances (8E1 defaults, 9O2), a fast
// bit clock (DIV = 4, 64 clk per bit) and an expected-word queue.
module tb_uart_rx_param;

  localparam int unsigned CLK_FREQ = 2457600;  // 2457600 / (38400 * 16) = 4
  localparam int unsigned BAUD     = 38400;
  localparam int          BitClks  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(9)) ifb ();

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
    .OVERSAMPLE(16)
  ) dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .bus(ifa)
  );

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(2),
    .OVERSAMPLE(16)
  ) dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .bus(ifb)
  );

  int errors = 0;
  int checks = 0;
  int pe_a = 0, fe_a = 0, ov_a = 0;
  int pe_b = 0, fe_b = 0, ov_b = 0;
  logic [8:0] exp_q[$];

  // Count high cycles of each pulse, so a count of 1 also means 1 clk wide.
  always @(negedge clk) begin
    if (ifa.parity_err) pe_a <= pe_a + 1;
    if (ifa.frame_err)  fe_a <= fe_a + 1;
    if (ifa.overrun)    ov_a <= ov_a + 1;
    if (ifb.parity_err) pe_b <= pe_b + 1;
    if (ifb.frame_err)  fe_b <= fe_b + 1;
    if (ifb.overrun)    ov_b <= ov_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel_b, input logic b);
    if (sel_b) rxd_b = b;
    else       rxd_a = b;
    repeat (BitClks) @(negedge clk);
  endtask

  // pmode: 0 none, 1 even, 2 odd; flip inverts the parity bit; gap of 2 idle bits.
  task automatic send(input bit sel_b, input logic [8:0] data, input int nbits,
                      input int pmode, input bit flip, input logic stop_v, input int nstop);
    logic p;
    drive(sel_b, 1'b0);
    for (int i = 0; i < nbits; i++) drive(sel_b, data[i]);
    if (pmode != 0) begin
      p = 1'b0;
      for (int i = 0; i < nbits; i++) p = p ^ data[i];
      if (pmode == 2) p = ~p;
      drive(sel_b, p ^ flip);
    end
    for (int i = 0; i < nstop; i++) drive(sel_b, stop_v);
    drive(sel_b, 1'b1);
    drive(sel_b, 1'b1);
  endtask

  task automatic consume_a();
    ifa.ready = 1'b1;
    @(negedge clk);
    ifa.ready = 1'b0;
  endtask

  initial begin
    logic [8:0] w;
    bit found;
    ifa.ready = 1'b0;
    ifb.ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_dout", ifa.dout, 0);
    chk("rst_valid", ifa.valid, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_flags", {ifa.parity_err, ifa.frame_err, ifa.overrun}, 0);
    rst = 1'b0;
    repeat (BitClks) @(negedge clk);

    // 1: good frame, then handshake
    exp_q.push_back(9'h0A5);
    send(0, 9'h0A5, 8, 1, 0, 1'b1, 1);
    w = exp_q.pop_front();
    chk("t1_valid", ifa.valid, 1);
    chk("t1_dout", ifa.dout, w);
    chk("t1_flags", pe_a + fe_a + ov_a, 0);
    consume_a();
    chk("t1_valid_clr", ifa.valid, 0);

    // 2: bad parity
    send(0, 9'h0A5, 8, 1, 1, 1'b1, 1);
    chk("t2_pe_pulse", pe_a, 1);
    chk("t2_valid", ifa.valid, 0);
    chk("t2_dout", ifa.dout, 9'h0A5);

    // 3: stop bit low, then a good frame
    send(0, 9'h03C, 8, 1, 0, 1'b0, 1);
    chk("t3_fe_pulse", fe_a, 1);
    chk("t3_valid", ifa.valid, 0);
    chk("t3_pe_quiet", pe_a, 1);
    exp_q.push_back(9'h055);
    send(0, 9'h055, 8, 1, 0, 1'b1, 1);
    w = exp_q.pop_front();
    chk("t3_valid2", ifa.valid, 1);
    chk("t3_dout2", ifa.dout, w);
    consume_a();

    // 4: overrun, then ready coinciding with the completion clk
    exp_q.push_back(9'h011);
    send(0, 9'h011, 8, 1, 0, 1'b1, 1);
    w = exp_q.pop_front();
    chk("t4_dout11", ifa.dout, w);
    send(0, 9'h022, 8, 1, 0, 1'b1, 1);
    chk("t4_ov_pulse", ov_a, 1);
    chk("t4_dout_kept", ifa.dout, 9'h011);
    chk("t4_valid_kept", ifa.valid, 1);
    exp_q.push_back(9'h022);
    found = 1'b0;
    fork
      send(0, 9'h022, 8, 1, 0, 1'b1, 1);
      begin
        for (int i = 0; i < 1500; i++) begin
          @(negedge clk);
          if (dut_a.done) begin
            ifa.ready = 1'b1;
            @(negedge clk);
            ifa.ready = 1'b0;
            found = 1'b1;
            break;
          end
        end
      end
    join
    chk("t4_done_seen", found, 1);
    w = exp_q.pop_front();
    chk("t4_valid_sim", ifa.valid, 1);
    chk("t4_dout_sim", ifa.dout, w);
    chk("t4_no_ov", ov_a, 1);

    // 5: glitch on idle line, then 9O2 frame
    rxd_b = 1'b0;
    repeat (6) @(negedge clk);
    rxd_b = 1'b1;
    repeat (80) @(negedge clk);
    chk("t5_busy", ifb.busy, 0);
    chk("t5_valid", ifb.valid, 0);
    chk("t5_flags", pe_b + fe_b + ov_b, 0);
    exp_q.push_back(9'h1FF);
    send(1, 9'h1FF, 9, 2, 0, 1'b1, 2);
    w = exp_q.pop_front();
    chk("t5_valid9", ifb.valid, 1);
    chk("t5_dout9", ifb.dout, w);
    chk("t5_flags9", pe_b + fe_b + ov_b, 0);

    // 6: reset during data bit 4 of 0x81, then a clean 0x81
    drive(0, 1'b0);
    drive(0, 1'b1);
    drive(0, 1'b0);
    drive(0, 1'b0);
    drive(0, 1'b0);
    rxd_a = 1'b0;
    repeat (BitClks / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", ifa.busy, 0);
    chk("t6_valid", ifa.valid, 0);
    rst = 1'b0;
    rxd_a = 1'b1;
    repeat (3 * BitClks) @(negedge clk);
    chk("t6_idle", ifa.busy, 0);
    chk("t6_flags", pe_a + fe_a + ov_a, 3);
    exp_q.push_back(9'h081);
    send(0, 9'h081, 8, 1, 0, 1'b1, 1);
    w = exp_q.pop_front();
    chk("t6_valid81", ifa.valid, 1);
    chk("t6_dout81", ifa.dout, w);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. Successor to the fixed 8-bit, 38400-baud, even-parity-check receiver.
- Generalised: data width, parity mode (none/even/odd), stop-bit count and baud rate.
- Added: 16x oversampling with majority vote, false-start rejection, framing and overrun detection, and a valid/ready output handshake.
- Sits between the DIF serial configuration pin and the command decoder.

Parameters:
CLK_FREQ, 40000000, system clock frequency in Hz
BAUD, 38400, line bit rate in bit/s
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, samples per bit; fixed legal value 16

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
rxd  input  1  asynchronous serial line; idles high
dout  output  DATA_BITS  received word, LSB = first data bit on the line
valid  output  1  dout holds an unconsumed word
ready  input  1  consumer accepts dout when valid && ready
parity_err  output  1  one-cycle pulse: parity mismatch
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: good frame dropped because valid was still high
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: dout=0, valid=0, all error pulses=0, busy=0, state=IDLE, synchroniser flops=1.
- Input path: rxd passes through a 2-flop synchroniser. rxs denotes the second flop.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division; 65 at the defaults.
  - Free-running counter 0..DIV-1. tick = 1 for one clk when the counter equals DIV-1.
  - Counter clears on rst.
- Sample counter: 4-bit scnt, advances on tick, wraps 15->0. Cleared on entry to START.
- Majority bit value: the majority of rxs captured at scnt = 7, 8, 9. It is evaluated when scnt = 9.
- States:
  - IDLE: rxs = 0 on a tick -> START.
  - START: majority = 1 at scnt = 9 -> IDLE (false start, no flags). At scnt = 15 on a tick -> DATA.
  - DATA: shift the majority bit into shift[bitcnt] at scnt = 9. bitcnt 0..DATA_BITS-1. At scnt = 15 of the last bit -> PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: compute expected parity. Even: expected = ^data. Odd: expected = ~^data. Record a mismatch at scnt = 9. At scnt = 15 -> STOP.
  - STOP: at scnt = 9 of each stop bit, majority = 0 sets the frame error. After the last stop bit's scnt = 9 sample -> DONE. Do not wait for scnt = 15, so back-to-back frames resynchronise.
  - DONE: lasts exactly one clk, then -> IDLE. Completion actions happen in this clk (see below).
- DONE completion priority:
  1. Frame error: frame_err = 1; dout and valid unchanged. Parity is not reported for this frame.
  2. Otherwise parity error: parity_err = 1; dout and valid unchanged.
  3. Otherwise, if valid = 1 and ready = 0: overrun = 1; the new word is dropped and the old dout is kept.
  4. Otherwise: dout <= shift, valid <= 1.
- Handshake:
  - valid clears on the clk after valid && ready, unless DONE loads a new word in the same clk.
  - Simultaneous ready and DONE-load: valid stays 1, dout takes the new word, no overrun.
  - dout is stable while valid = 1.
- Reset mid-frame: rst during any state returns to IDLE next clk. Partial data is discarded and no flags are raised.
- rxd held low permanently (break condition): one frame_err, then IDLE. IDLE re-arms immediately, so frame_err repeats once per frame time until the line returns high.
- Latency: valid rises 1 clk after the tick at scnt = 9 of the last stop bit, plus the 2-clk synchroniser delay.

Test Plan:
1. Defaults; send 0xA5 with parity bit 0 and stop 1; ready held low -> valid = 1, dout = 0xA5, no flags. Then ready = 1 for 1 clk -> valid = 0 next clk.
2. Send 0xA5 with parity bit 1 -> parity_err pulses for exactly 1 clk; valid stays 0; dout keeps its previous value.
3. Send 0x3C with the stop bit driven 0 -> frame_err pulse, no valid. Next correct frame 0x55 -> valid = 1, dout = 0x55.
4. Send 0x11 with ready = 0, then 0x22 -> overrun pulse, dout remains 0x11. Repeat with ready = 1 in the DONE clk -> dout = 0x22, valid = 1, no overrun.
5. 6-clk glitch low on idle rxd -> state returns to IDLE, no valid and no flags. Then send DATA_BITS = 9, PARITY_MODE = 2, STOP_BITS = 2, word 0x1FF (odd parity bit 0) -> dout = 0x1FF.
6. Assert rst during bit 4 of a frame -> busy = 0 next clk, valid = 0. Next clean frame 0x81 is received correctly.
